// File: rtl/akumulator_bank.sv
// akumulator_bank: a bank of N_ACC independent DATA_W-bit accumulators.
//
// LOAD / ADD / SUB / CLR and NOP complete in one cycle. SHL / SHR / SAR
// shift the target channel one bit per clock. op_ready is low while a
// shift is in progress, and done pulses for one cycle after the final
// write of every accepted op. Each channel keeps its own C/Z/N/V flags.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   a             operand
//   op            000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 CLR,
//                 101 SHL, 110 SHR, 111 SAR
//   sel           target channel of op
//   shamt         shift amount for the shift ops
//   op_valid      request; accepted when op_valid & op_ready at an edge
//   op_ready      high while idle
//   done          one-cycle completion pulse
//   rd_sel        read channel
//   out, flag_*   value and flags of channel rd_sel (combinational)
module akumulator_bank #(
    parameter int DATA_W  = 8,
    parameter int N_ACC   = 4,
    parameter int SAT     = 0,
    parameter int SEL_W   = (N_ACC > 1) ? $clog2(N_ACC) : 1,
    parameter int SHAMT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  a,
    input  logic [2:0]         op,
    input  logic [SEL_W-1:0]   sel,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               op_valid,
    output logic               op_ready,
    output logic               done,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [DATA_W-1:0]  out,
    output logic               flag_c,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_v
);

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_SAR  = 3'b111;

    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [SEL_W:0]    N_ACC_L = (SEL_W+1)'(N_ACC);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q [N_ACC];
    logic [DATA_W-1:0]   acc_d [N_ACC];
    logic [N_ACC-1:0]    c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic [2:0]          op_q, op_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic                done_q, done_d;

    logic                sel_ok, rd_ok;
    logic [DATA_W-1:0]   cur;
    logic [DATA_W:0]     sum_ext, diff_ext;
    logic                add_v, sub_v;
    logic [DATA_W-1:0]   sh_src, sh_val;
    logic [2:0]          sh_op;
    logic                sh_bit;

    // Indices beyond N_ACC only exist when N_ACC is not a power of two.
    assign sel_ok = ({1'b0, sel}    < N_ACC_L);
    assign rd_ok  = ({1'b0, rd_sel} < N_ACC_L);
    assign cur    = sel_ok ? acc_q[sel] : '0;

    assign sum_ext  = {1'b0, cur} + {1'b0, a};
    assign diff_ext = {1'b0, cur} - {1'b0, a};   // MSB is the borrow (a > cur)
    assign add_v = (cur[DATA_W-1] == a[DATA_W-1]) && (sum_ext[DATA_W-1]  != cur[DATA_W-1]);
    assign sub_v = (cur[DATA_W-1] != a[DATA_W-1]) && (diff_ext[DATA_W-1] != cur[DATA_W-1]);

    // The first bit-shift happens at the accept edge on the live inputs;
    // later ones use the latched op and channel.
    assign sh_op  = (state_q == SHIFT) ? op_q : op;
    assign sh_src = (state_q == SHIFT) ? acc_q[sel_q] : cur;

    always_comb begin
        sh_val = sh_src;
        sh_bit = 1'b0;
        case (sh_op)
            OP_SHL: begin
                sh_val = {sh_src[DATA_W-2:0], 1'b0};
                sh_bit = sh_src[DATA_W-1];
            end
            OP_SHR: begin
                sh_val = {1'b0, sh_src[DATA_W-1:1]};
                sh_bit = sh_src[0];
            end
            default: begin
                sh_val = {sh_src[DATA_W-1], sh_src[DATA_W-1:1]};
                sh_bit = sh_src[0];
            end
        endcase
    end

    logic                wr_acc, wr_flg, fc, fv;
    logic [SEL_W-1:0]    wr_ch;
    logic [DATA_W-1:0]   res;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        c_d     = c_q;
        z_d     = z_q;
        n_d     = n_q;
        v_d     = v_q;
        wr_acc  = 1'b0;
        wr_flg  = 1'b0;
        wr_ch   = sel;
        res     = cur;
        fc      = 1'b0;
        fv      = 1'b0;

        if (state_q == IDLE) begin
            if (op_valid) begin
                done_d = 1'b1;
                if (sel_ok) begin
                    case (op)
                        OP_LOAD: begin
                            res    = a;
                            wr_acc = 1'b1;
                            wr_flg = 1'b1;
                        end
                        OP_ADD: begin
                            res    = ((SAT != 0) && add_v) ? (cur[DATA_W-1] ? SMIN : SMAX)
                                                           : sum_ext[DATA_W-1:0];
                            fc     = sum_ext[DATA_W];
                            fv     = add_v;
                            wr_acc = 1'b1;
                            wr_flg = 1'b1;
                        end
                        OP_SUB: begin
                            res    = ((SAT != 0) && sub_v) ? (cur[DATA_W-1] ? SMIN : SMAX)
                                                           : diff_ext[DATA_W-1:0];
                            fc     = diff_ext[DATA_W];
                            fv     = sub_v;
                            wr_acc = 1'b1;
                            wr_flg = 1'b1;
                        end
                        OP_CLR: begin
                            res    = '0;
                            wr_acc = 1'b1;
                            wr_flg = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_SAR: begin
                            if (shamt == '0) begin
                                // Value kept, flags refreshed with C = 0.
                                wr_flg = 1'b1;
                            end else begin
                                res    = sh_val;
                                wr_acc = 1'b1;
                                if (shamt == SHAMT_W'(1)) begin
                                    fc     = sh_bit;
                                    wr_flg = 1'b1;
                                end else begin
                                    state_d = SHIFT;
                                    op_d    = op;
                                    sel_d   = sel;
                                    cnt_d   = shamt - SHAMT_W'(1);
                                    done_d  = 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else begin
            // cnt_q holds the number of bit-shifts still to do.
            wr_ch  = sel_q;
            res    = sh_val;
            wr_acc = 1'b1;
            cnt_d  = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
                fc      = sh_bit;
                wr_flg  = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        if (wr_acc) begin
            acc_d[wr_ch] = res;
        end
        if (wr_flg) begin
            c_d[wr_ch] = fc;
            v_d[wr_ch] = fv;
            z_d[wr_ch] = (res == '0);
            n_d[wr_ch] = res[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < N_ACC; i++) begin
                acc_q[i] <= '0;
            end
            c_q    <= '0;
            z_q    <= '0;
            n_q    <= '0;
            v_q    <= '0;
            op_q   <= '0;
            sel_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            n_q     <= n_d;
            v_q     <= v_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign op_ready = (state_q == IDLE);
    assign done     = done_q;
    assign out      = rd_ok ? acc_q[rd_sel] : '0;
    assign flag_c   = rd_ok & c_q[rd_sel];
    assign flag_z   = rd_ok & z_q[rd_sel];
    assign flag_n   = rd_ok & n_q[rd_sel];
    assign flag_v   = rd_ok & v_q[rd_sel];

endmodule
